// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and funct3 legality check for the load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_DONE   = 2'd2,
        LSU_TRAP   = 2'd3
    } lsu_state_e;

    // Doubleword and unsigned-word forms only exist on a 64-bit datapath.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3,
                                      input logic xlen64);
        logic ok;
        if (is_store) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (xlen64 && (f3 == F3_D));
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU) ||
                 (xlen64 && ((f3 == F3_D) || (f3 == F3_WU)));
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_aligner.sv
// Byte-lane aligner: builds lane mask and replicated write data, extracts/extends read data.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: funct3/off select size and lane; store_data -> wdata; rdata -> load_val;
//        misaligned flags an offset not aligned to the access size.
module lsu_lane_aligner
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                   funct3,
    input  logic [$clog2(XLEN/8)-1:0]    off,
    input  logic [XLEN-1:0]              store_data,
    input  logic [XLEN-1:0]              rdata,
    output logic [XLEN/8-1:0]            mask,
    output logic [XLEN-1:0]              wdata,
    output logic [XLEN-1:0]              load_val,
    output logic                         misaligned
);

    localparam int MW = XLEN / 8;
    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] shifted;
    int              nbits;
    logic            sgn;
    logic [SW-1:0]   sidx;
    logic            sbit;

    // Size comes from funct3[1:0]; the unsigned variants share the same size code.
    always_comb begin
        mask       = '0;
        wdata      = store_data;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                mask  = MW'(1) << off;
                wdata = {MW{store_data[7:0]}};
            end
            2'b01: begin
                mask       = MW'(3) << off;
                wdata      = {(XLEN/16){store_data[15:0]}};
                misaligned = off[0];
            end
            2'b10: begin
                mask       = MW'(15) << off;
                wdata      = {(XLEN/32){store_data[31:0]}};
                misaligned = (off[1:0] != 2'b00);
            end
            default: begin
                mask       = '1;
                wdata      = store_data;
                misaligned = (off != '0);
            end
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend from the access width.
    always_comb begin
        shifted = rdata >> {off, 3'b000};
        nbits   = XLEN;
        sgn     = 1'b0;
        case (funct3)
            F3_B:    begin nbits = 8;  sgn = 1'b1; end
            F3_H:    begin nbits = 16; sgn = 1'b1; end
            F3_W:    begin nbits = 32; sgn = 1'b1; end
            F3_BU:   begin nbits = 8;  sgn = 1'b0; end
            F3_HU:   begin nbits = 16; sgn = 1'b0; end
            F3_WU:   begin nbits = 32; sgn = 1'b0; end
            default: begin nbits = XLEN; sgn = 1'b0; end
        endcase
        sidx = SW'(nbits - 1);
        sbit = shifted[sidx];
        load_val = '0;
        for (int i = 0; i < XLEN; i++) begin
            load_val[i] = (i < nbits) ? shifted[i] : (sgn & sbit);
        end
    end

endmodule

// File: rtl/load_store_controller.sv
// Load/store unit: latches one request, runs a req/ack data-memory transaction, returns extended load data.
// Latency: enable at N -> mem_req at N+1 -> done one cycle after mem_ack; misaligned traps give done at N+1.
// Backpressure: new requests only accepted in IDLE (busy low); waits on mem_ack indefinitely unless
//               LSU_TIMEOUT_EN is defined, which bounds the wait to TIMEOUT_CYCLES and reports bus_error.
// Ports: CLK/reset (sync, active-high); enable/opcode/funct3/address/store_data request;
//        busy/done/misaligned/bus_error/load_data status; mem_* data-memory port.
module load_store_controller
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [XLEN-1:0]       store_data,
    output logic                  busy,
    output logic                  done,
    output logic                  misaligned,
    output logic                  bus_error,
    output logic [XLEN-1:0]       load_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [XLEN/8-1:0]     mem_mask,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  mem_ack
);

    localparam int MW   = XLEN / 8;
    localparam int OFFW = $clog2(MW);

    lsu_state_e            state_q, state_d;
    logic [6:0]            opcode_q, opcode_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       sdata_q, sdata_d;
    logic [XLEN-1:0]       load_data_q, load_data_d;
    logic                  busy_q, busy_d;

    logic                  in_idle;
    logic                  in_access;
    logic                  is_store_q;
    logic                  op_legal;
    logic                  f3_ok;
    logic [2:0]            al_f3;
    logic [OFFW-1:0]       al_off;
    logic [MW-1:0]         al_mask;
    logic [XLEN-1:0]       al_wdata;
    logic [XLEN-1:0]       al_load;
    logic                  al_mis;

`ifdef LSU_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 255) ? 16 : 8;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          berr_q, berr_d;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
`endif

    assign in_idle    = (state_q == LSU_IDLE);
    assign in_access  = (state_q == LSU_ACCESS);
    assign is_store_q = (opcode_q == OP_STORE);
    assign op_legal   = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign f3_ok      = f3_legal(opcode == OP_STORE, funct3, XLEN == 64);

    // One aligner serves both jobs: in IDLE it checks the incoming request's alignment,
    // afterwards it works from the latched request for lanes, write data and extraction.
    assign al_f3  = in_idle ? funct3 : funct3_q;
    assign al_off = in_idle ? address[OFFW-1:0] : addr_q[OFFW-1:0];

    lsu_lane_aligner #(
        .XLEN (XLEN)
    ) u_aligner (
        .funct3     (al_f3),
        .off        (al_off),
        .store_data (sdata_q),
        .rdata      (mem_rdata),
        .mask       (al_mask),
        .wdata      (al_wdata),
        .load_val   (al_load),
        .misaligned (al_mis)
    );

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        load_data_d = load_data_q;
`ifdef LSU_TIMEOUT_EN
        tmo_d       = tmo_q;
        berr_d      = 1'b0;
`endif
        case (state_q)
            LSU_IDLE: begin
                if (enable && op_legal) begin
                    if (!f3_ok || al_mis) begin
                        state_d = LSU_TRAP;
                    end else begin
                        opcode_d = opcode;
                        funct3_d = funct3;
                        addr_d   = address;
                        sdata_d  = store_data;
                        state_d  = LSU_ACCESS;
`ifdef LSU_TIMEOUT_EN
                        tmo_d    = '0;
`endif
                    end
                end
            end
            LSU_ACCESS: begin
                // An ack in the terminal cycle wins over the timeout.
                if (mem_ack) begin
                    if (!is_store_q) begin
                        load_data_d = al_load;
                    end
                    state_d = LSU_DONE;
`ifdef LSU_TIMEOUT_EN
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    berr_d  = 1'b1;
                    state_d = LSU_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
`endif
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            LSU_TRAP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
        busy_d = (state_d != LSU_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= LSU_IDLE;
            opcode_q    <= '0;
            funct3_q    <= '0;
            addr_q      <= '0;
            sdata_q     <= '0;
            load_data_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            load_data_q <= load_data_d;
            busy_q      <= busy_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (reset) begin
            tmo_q  <= '0;
            berr_q <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            berr_q <= berr_d;
        end
    end
    assign bus_error = berr_q;
`else
    assign bus_error = 1'b0;
`endif

    assign busy       = busy_q;
    assign done       = (state_q == LSU_DONE) || (state_q == LSU_TRAP);
    assign misaligned = (state_q == LSU_TRAP);
    assign load_data  = load_data_q;

    // Memory-port fields are only meaningful during ACCESS; zero them elsewhere.
    assign mem_req   = in_access;
    assign mem_we    = in_access && is_store_q;
    assign mem_mask  = in_access ? al_mask : '0;
    assign mem_addr  = in_access ? {addr_q[ADDR_WIDTH-1:OFFW], OFFW'(0)} : '0;
    assign mem_wdata = in_access ? al_wdata : '0;

endmodule

// File: tb/tb_load_store_controller.sv
module tb_load_store_controller;
    import lsu_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, sel, mem_ack;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [63:0] sd, rd;
    logic        en32, en64;

    assign en32 = enable & ~sel;
    assign en64 = enable & sel;

    logic        b32, d32, m32, e32, req32, we32;
    logic [31:0] ld32, ma32, wd32;
    logic [3:0]  mask32;
    logic        b64, d64, m64, e64, req64, we64;
    logic [63:0] ld64, wd64;
    logic [31:0] ma64;
    logic [7:0]  mask64;

    load_store_controller #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut32 (
        .CLK(clk), .reset(reset), .enable(en32), .opcode(opcode), .funct3(funct3),
        .address(address), .store_data(sd[31:0]), .busy(b32), .done(d32),
        .misaligned(m32), .bus_error(e32), .load_data(ld32), .mem_req(req32),
        .mem_we(we32), .mem_mask(mask32), .mem_addr(ma32), .mem_wdata(wd32),
        .mem_rdata(rd[31:0]), .mem_ack(mem_ack)
    );

    load_store_controller #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut64 (
        .CLK(clk), .reset(reset), .enable(en64), .opcode(opcode), .funct3(funct3),
        .address(address), .store_data(sd), .busy(b64), .done(d64),
        .misaligned(m64), .bus_error(e64), .load_data(ld64), .mem_req(req64),
        .mem_we(we64), .mem_mask(mask64), .mem_addr(ma64), .mem_wdata(wd64),
        .mem_rdata(rd), .mem_ack(mem_ack)
    );

    logic        s_busy, s_done, s_mis, s_berr, s_req, s_we;
    logic [7:0]  s_mask;
    logic [31:0] s_addr;
    logic [63:0] s_wdata, s_ld;

    always_comb begin
        if (sel) begin
            s_busy = b64; s_done = d64; s_mis = m64; s_berr = e64; s_req = req64; s_we = we64;
            s_mask = mask64; s_addr = ma64; s_wdata = wd64; s_ld = ld64;
        end else begin
            s_busy = b32; s_done = d32; s_mis = m32; s_berr = e32; s_req = req32; s_we = we32;
            s_mask = {4'b0, mask32}; s_addr = ma32; s_wdata = {32'b0, wd32}; s_ld = {32'b0, ld32};
        end
    end

    typedef struct {
        logic        x64;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] sdv;
        logic [63:0] rdv;
        int          waits;
        logic        trap;
        logic [7:0]  mask;
        logic [31:0] maddr;
        logic [63:0] wdv;
        logic [63:0] ldv;
    } vec_t;

    typedef struct {
        logic        trap;
        logic        berr;
        logic [63:0] ld;
        int          dcyc;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    logic [63:0] model32, model64;
    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic x64, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [63:0] sdv,
                                input logic [63:0] rdv, input int w, input logic trap,
                                input logic [7:0] mask, input logic [31:0] ma,
                                input logic [63:0] wdv, input logic [63:0] ldv);
        vec_t v;
        v.x64 = x64; v.st = st; v.f3 = f3; v.addr = a; v.sdv = sdv; v.rdv = rdv;
        v.waits = w; v.trap = trap; v.mask = mask; v.maddr = ma; v.wdv = wdv; v.ldv = ldv;
        return v;
    endfunction

    task automatic run(input vec_t v);
        exp_t e;
        int   cyc;
        @(negedge clk);
        chk("done_pulse_width", 64'(s_done), 64'(0));
        sel     = v.x64;
        opcode  = v.st ? OP_STORE : OP_LOAD;
        funct3  = v.f3;
        address = v.addr;
        sd      = v.sdv;
        rd      = v.rdv;
        enable  = 1'b1;
        e.trap  = v.trap;
`ifdef LSU_TIMEOUT_EN
        e.berr  = !v.trap && (v.waits >= TMO);
`else
        e.berr  = 1'b0;
`endif
        if (!v.trap && !v.st && !e.berr) begin
            if (v.x64) model64 = v.ldv;
            else       model32 = v.ldv;
        end
        e.ld   = v.x64 ? model64 : model32;
        e.dcyc = v.trap ? 1 : (e.berr ? TMO + 1 : v.waits + 2);
        sb.push_back(e);
        @(negedge clk);
        enable = 1'b0;
        cyc = 1;
        while (!s_done && cyc < 40) begin
            chk("mem_req", 64'(s_req), 64'(1));
            chk("busy", 64'(s_busy), 64'(1));
            chk("mem_we", 64'(s_we), 64'(v.st));
            chk("mem_mask", 64'(s_mask), 64'(v.mask));
            chk("mem_addr", 64'(s_addr), 64'(v.maddr));
            if (v.st) chk("mem_wdata", s_wdata, v.wdv);
            mem_ack = (cyc == v.waits + 1);
            @(negedge clk);
            mem_ack = 1'b0;
            cyc++;
        end
        e = sb.pop_front();
        chk("done", 64'(s_done), 64'(1));
        chk("done_cycle", 64'(cyc), 64'(e.dcyc));
        chk("misaligned", 64'(s_mis), 64'(e.trap));
        chk("bus_error", 64'(s_berr), 64'(e.berr));
        chk("load_data", s_ld, e.ld);
        chk("req_at_done", 64'(s_req), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy32"}, 64'(b32), 64'(0));
        chk({tag, "_done32"}, 64'(d32), 64'(0));
        chk({tag, "_req32"}, 64'(req32), 64'(0));
        chk({tag, "_ld32"}, 64'(ld32), 64'(0));
        chk({tag, "_mask32"}, 64'(mask32), 64'(0));
        chk({tag, "_addr32"}, 64'(ma32), 64'(0));
        chk({tag, "_wd32"}, 64'(wd32), 64'(0));
        chk({tag, "_mis32"}, 64'(m32), 64'(0));
        chk({tag, "_berr32"}, 64'(e32), 64'(0));
        chk({tag, "_ld64"}, ld64, 64'(0));
        chk({tag, "_busy64"}, 64'(b64), 64'(0));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sel = 1'b0; mem_ack = 1'b0;
        opcode = '0; funct3 = '0; address = '0; sd = '0; rd = '0;
        model32 = '0; model64 = '0;

        //        x64 st  f3      addr        sd                     rd                     w  trap mask   maddr       wdata                  load
        vt.push_back(mk(0, 0, 3'b000, 32'h103, 64'h0, 64'h80FF_1122, 0, 0, 8'h08, 32'h100, 64'h0, 64'hFFFF_FF80));
        vt.push_back(mk(0, 1, 3'b001, 32'h202, 64'h0000_ABCD, 64'h0, 3, 0, 8'h0C, 32'h200, 64'hABCD_ABCD, 64'h0));
        vt.push_back(mk(0, 0, 3'b010, 32'h101, 64'h0, 64'h0, 0, 1, 8'h00, 32'h0, 64'h0, 64'h0));
        vt.push_back(mk(0, 0, 3'b011, 32'h100, 64'h0, 64'h0, 0, 1, 8'h00, 32'h0, 64'h0, 64'h0));
        vt.push_back(mk(0, 0, 3'b100, 32'h101, 64'h0, 64'h1234_80FF, 1, 0, 8'h02, 32'h100, 64'h0, 64'h80));
        vt.push_back(mk(0, 0, 3'b001, 32'h102, 64'h0, 64'h8001_7FFF, 2, 0, 8'h0C, 32'h100, 64'h0, 64'hFFFF_8001));
        vt.push_back(mk(0, 0, 3'b101, 32'h100, 64'h0, 64'h1234_8001, 0, 0, 8'h03, 32'h100, 64'h0, 64'h8001));
        vt.push_back(mk(0, 0, 3'b010, 32'h104, 64'h0, 64'hDEAD_BEEF, 1, 0, 8'h0F, 32'h104, 64'h0, 64'hDEAD_BEEF));
        vt.push_back(mk(0, 1, 3'b000, 32'h003, 64'h1234_56A5, 64'h0, 0, 0, 8'h08, 32'h0, 64'hA5A5_A5A5, 64'h0));
        vt.push_back(mk(0, 1, 3'b010, 32'h008, 64'hCAFE_F00D, 64'h0, 2, 0, 8'h0F, 32'h8, 64'hCAFE_F00D, 64'h0));
        vt.push_back(mk(0, 1, 3'b001, 32'h001, 64'h0, 64'h0, 0, 1, 8'h00, 32'h0, 64'h0, 64'h0));
        vt.push_back(mk(0, 1, 3'b100, 32'h000, 64'h0, 64'h0, 0, 1, 8'h00, 32'h0, 64'h0, 64'h0));
        vt.push_back(mk(0, 0, 3'b111, 32'h000, 64'h0, 64'h0, 0, 1, 8'h00, 32'h0, 64'h0, 64'h0));
        vt.push_back(mk(1, 0, 3'b110, 32'h104, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 8'hF0, 32'h100, 64'h0, 64'h0000_0000_8765_4321));
        vt.push_back(mk(1, 0, 3'b010, 32'h104, 64'h0, 64'h8765_4321_0000_0000, 1, 0, 8'hF0, 32'h100, 64'h0, 64'hFFFF_FFFF_8765_4321));
        vt.push_back(mk(1, 1, 3'b011, 32'h108, 64'h1122_3344_5566_7788, 64'h0, 0, 0, 8'hFF, 32'h108, 64'h1122_3344_5566_7788, 64'h0));
        vt.push_back(mk(1, 0, 3'b011, 32'h104, 64'h0, 64'h0, 0, 1, 8'h00, 32'h0, 64'h0, 64'h0));
        vt.push_back(mk(1, 1, 3'b000, 32'h105, 64'h5A, 64'h0, 0, 0, 8'h20, 32'h100, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0));
`ifdef LSU_TIMEOUT_EN
        vt.push_back(mk(0, 0, 3'b010, 32'h020, 64'h0, 64'h0, 100, 0, 8'h0F, 32'h20, 64'h0, 64'h0));
        vt.push_back(mk(0, 0, 3'b000, 32'h000, 64'h0, 64'h7F, 0, 0, 8'h01, 32'h0, 64'h0, 64'h7F));
`endif

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        foreach (vt[i]) run(vt[i]);

        // Back-to-back: enable held through the DONE cycle is only taken the cycle after.
        run(mk(0, 0, 3'b010, 32'h40, 64'h0, 64'h0102_0304, 0, 0, 8'h0F, 32'h40, 64'h0, 64'h0102_0304));
        sel = 1'b0; opcode = OP_LOAD; funct3 = F3_W; address = 32'h41; enable = 1'b1;
        @(negedge clk);
        chk("b2b_not_in_done", 64'(s_done), 64'(0));
        @(negedge clk);
        chk("b2b_trap_done", 64'(s_done), 64'(1));
        chk("b2b_trap_mis", 64'(s_mis), 64'(1));
        enable = 1'b0;
        @(negedge clk);
        chk("b2b_after", 64'(s_done), 64'(0));

        // Illegal opcode is ignored.
        opcode = 7'b0110011; funct3 = F3_B; address = 32'h0; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        chk("illegal_op_busy", 64'(s_busy), 64'(0));
        @(negedge clk);
        chk("illegal_op_done", 64'(s_done), 64'(0));
        chk("illegal_op_req", 64'(s_req), 64'(0));

        // Reset during ACCESS, with an ack arriving in the reset cycle and after.
        opcode = OP_LOAD; funct3 = F3_W; address = 32'h10; rd = 64'h5555_AAAA; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        chk("rst_seq_req", 64'(s_req), 64'(1));
        @(negedge clk);
        reset = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model32 = '0; model64 = '0;
        check_all_zero("rst_access");
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rst_late_ack_done", 64'(s_done), 64'(0));
        chk("rst_late_ack_req", 64'(s_req), 64'(0));
        @(negedge clk);
        chk("rst_late_ack_ld", 64'(s_ld), 64'(0));
        chk("rst_late_ack_busy", 64'(s_busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
